// File: rtl/log_sched_pkg.sv
// log_sched_pkg: shared types and helpers for the log unit scheduler.
//   state_t   : scheduler FSM states (IDLE waits for a request, BUSY owns a frame)
//   LOG_I_BW  : input width of the shared log unit
//   LOG_O_BW  : output width of the shared log unit
//   id_width(): ceil(log2(n)) with a floor of 1, used for ID and counter widths
package log_sched_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int LOG_I_BW = 32;
    localparam int LOG_O_BW = 8;

    function automatic int id_width(input int n);
        int w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/log_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_req   : request vector, one bit per requester
//   i_ptr   : highest-priority index this round
//   o_grant : first requesting index at or after i_ptr, wrapping
//   o_any   : at least one request is present
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_BW   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_BW-1:0]   i_ptr,
    output logic [ID_BW-1:0]   o_grant,
    output logic               o_any
);

    logic [ID_BW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = ID_BW'((int'(i_ptr) + off) % NUM_REQ);
            if (i_req[w_idx]) o_grant = w_idx;
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/log_sched.sv
// log_sched: frame-level round-robin scheduler in front of one shared log unit.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   en_i                    : global enable; low freezes state and blocks transfers
//   req_data/valid/last_i   : per-requester beat streams
//   req_ready_o             : per-requester accept (only the granted one, in BUSY)
//   log_data/valid/last_o   : granted beat routed to the log unit
//   log_data/valid/last_i   : combinational log unit result
//   data_o/valid_o/last_o   : registered result, last_o also marks forced ends
//   id_o                    : requester that produced the current output beat
//   err_o                   : pulse with the beat that hit MAX_LEN without last
module log_sched
    import log_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int I_BW    = LOG_I_BW,
    parameter int O_BW    = LOG_O_BW,
    parameter int ID_BW   = id_width(NUM_REQ),
    parameter int MAX_LEN = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    en_i,
    input  logic [NUM_REQ*I_BW-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [NUM_REQ-1:0]      req_last_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [I_BW-1:0]         log_data_o,
    output logic                    log_valid_o,
    output logic                    log_last_o,
    input  logic [O_BW-1:0]         log_data_i,
    input  logic                    log_valid_i,
    input  logic                    log_last_i,
    output logic [O_BW-1:0]         data_o,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [ID_BW-1:0]        id_o,
    output logic                    err_o
);

    localparam int CNT_BW = id_width(MAX_LEN);

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_BW-1:0]    r_ptr;
    logic [ID_BW-1:0]    r_grant;
    logic [CNT_BW-1:0]   r_cnt;
    logic [O_BW-1:0]     r_data;
    logic                r_valid;
    logic                r_last;
    logic [ID_BW-1:0]    r_id;
    logic                r_err;

    logic [ID_BW-1:0]    w_arb_grant;
    logic                w_arb_any;
    logic [I_BW-1:0]     w_beat [NUM_REQ];
    logic                w_busy;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_xfer;
    logic                w_at_max;
    logic                w_end;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_beat
            assign w_beat[gi] = req_data_i[gi*I_BW +: I_BW];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_BW   (ID_BW)
    ) u_arb (
        .i_req   (req_valid_i),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_any   (w_arb_any)
    );

    assign w_busy      = (r_state == BUSY);
    assign w_sel_valid = req_valid_i[r_grant];
    assign w_sel_last  = req_last_i[r_grant];
    assign w_xfer      = w_busy & en_i & w_sel_valid;
    assign w_at_max    = (r_cnt == CNT_BW'(MAX_LEN - 1));
    // The MAX_LEN-th beat closes the frame even without a last flag.
    assign w_end       = w_xfer & (w_sel_last | w_at_max);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  r_state <= IDLE;
        else if (en_i) r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_arb_any) w_state_next = BUSY;
            BUSY:    if (w_end)     w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    // FSM outputs: ready and the routed beat
    always_comb begin
        req_ready_o = '0;
        if (w_busy && en_i) req_ready_o[r_grant] = 1'b1;
        log_data_o  = w_beat[r_grant];
        log_valid_o = w_xfer;
        log_last_o  = w_busy & (w_sel_last | w_at_max);
    end

    // Grant, round-robin pointer and beat counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else if (en_i) begin
            if (!w_busy && w_arb_any) begin
                r_grant <= w_arb_grant;
            end
            if (w_end) begin
                r_ptr <= (r_grant == ID_BW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
                r_cnt <= '0;
            end else if (w_xfer) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register; data and id hold while disabled
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (en_i) begin
            r_data  <= log_data_i;
            r_valid <= log_valid_i;
            r_last  <= log_last_i;
            r_id    <= r_grant;
            r_err   <= w_xfer & w_at_max & ~w_sel_last;
        end else begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end
    end

    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign last_o  = r_last;
    assign id_o    = r_id;
    assign err_o   = r_err;

endmodule

// File: tb/tb_log_sched.sv
module tb_log_sched;

    localparam int NUM_REQ = 2;
    localparam int I_BW    = 32;
    localparam int O_BW    = 8;
    localparam int ID_BW   = 1;
    localparam int MAX_LEN = 32;

    logic                    clk_i = 1'b0;
    logic                    rst_n_i;
    logic                    en_i;
    logic [NUM_REQ*I_BW-1:0] req_data_i;
    logic [NUM_REQ-1:0]      req_valid_i;
    logic [NUM_REQ-1:0]      req_last_i;
    logic [NUM_REQ-1:0]      req_ready_o;
    logic [I_BW-1:0]         log_data_o;
    logic                    log_valid_o;
    logic                    log_last_o;
    logic [O_BW-1:0]         log_data_i;
    logic                    log_valid_i;
    logic                    log_last_i;
    logic [O_BW-1:0]         data_o;
    logic                    valid_o;
    logic                    last_o;
    logic [ID_BW-1:0]        id_o;
    logic                    err_o;

    always #5 clk_i = ~clk_i;

    log_sched #(
        .NUM_REQ (NUM_REQ), .I_BW (I_BW), .O_BW (O_BW),
        .ID_BW (ID_BW), .MAX_LEN (MAX_LEN)
    ) dut (
        .clk_i (clk_i), .rst_n_i (rst_n_i), .en_i (en_i),
        .req_data_i (req_data_i), .req_valid_i (req_valid_i),
        .req_last_i (req_last_i), .req_ready_o (req_ready_o),
        .log_data_o (log_data_o), .log_valid_o (log_valid_o),
        .log_last_o (log_last_o), .log_data_i (log_data_i),
        .log_valid_i (log_valid_i), .log_last_i (log_last_i),
        .data_o (data_o), .valid_o (valid_o), .last_o (last_o),
        .id_o (id_o), .err_o (err_o)
    );

    // Stand-in log unit: bit length of the input, 32 for zero.
    function automatic logic [7:0] logf(input logic [31:0] x);
        logf = 8'd32;
        if (x != 0) for (int i = 0; i < 32; i++) if (x[i]) logf = 8'(i + 1);
    endfunction

    assign log_data_i  = logf(log_data_o);
    assign log_valid_i = log_valid_o;
    assign log_last_i  = log_last_o;

    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [7:0] data; int id; logic last; logic err; } exp_t;

    beat_t src_q [NUM_REQ][$];
    beat_t mdl_q [NUM_REQ][$];
    exp_t  exp_q [$];
    int    mdl_ptr = 0;
    int    pass_cnt = 0;
    int    chk_cnt = 0;
    int    cyc = 0;
    int    first_cyc = -1;
    int    last_cyc = -1;
    logic [NUM_REQ-1:0] xfer = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic add_beat(input int k, input logic [31:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        src_q[k].push_back(b);
        mdl_q[k].push_back(b);
    endtask

    // Frame of n beats; requesters get different magnitude patterns.
    task automatic add_frame(input int k, input int n, input logic with_last);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            d = 32'd1 << ((i * 5 + k * 13) % 32);
            if (i % 7 == 6) d = 32'd0;
            add_beat(k, d, with_last && (i == n - 1));
        end
    endtask

    // Frame-level model: every queued beat is available, so frames are served
    // whole in round-robin order, split at MAX_LEN beats.
    task automatic run_model();
        int    k;
        int    n;
        bit    done;
        beat_t b;
        exp_t  e;
        while (mdl_q[0].size() + mdl_q[1].size() > 0) begin
            k = -1;
            for (int off = 0; off < NUM_REQ; off++)
                if (k < 0 && mdl_q[(mdl_ptr + off) % NUM_REQ].size() > 0)
                    k = (mdl_ptr + off) % NUM_REQ;
            n = 0;
            done = 0;
            while (!done) begin
                b = mdl_q[k].pop_front();
                n++;
                e.data = logf(b.data);
                e.id   = k;
                e.last = b.last || (n == MAX_LEN);
                e.err  = (n == MAX_LEN) && !b.last;
                exp_q.push_back(e);
                done = b.last || (n == MAX_LEN) || (mdl_q[k].size() == 0);
            end
            mdl_ptr = (k + 1) % NUM_REQ;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() + src_q[0].size() + src_q[1].size()) != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_drained"}, exp_q.size() + src_q[0].size() + src_q[1].size(), 0);
        repeat (2) @(negedge clk_i);
    endtask

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    initial forever begin
        @(negedge clk_i);
        xfer = req_valid_i & req_ready_o;
    end

    // Requester sources: hold the head beat until it is accepted.
    initial begin
        req_valid_i = '0;
        req_last_i  = '0;
        req_data_i  = '0;
        forever begin
            @(posedge clk_i);
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (xfer[k] && rst_n_i && src_q[k].size() > 0) void'(src_q[k].pop_front());
                if (src_q[k].size() > 0) begin
                    req_valid_i[k] = 1'b1;
                    req_last_i[k]  = src_q[k][0].last;
                    req_data_i[k*I_BW +: I_BW] = src_q[k][0].data;
                end else begin
                    req_valid_i[k] = 1'b0;
                    req_last_i[k]  = 1'b0;
                    req_data_i[k*I_BW +: I_BW] = '0;
                end
            end
            xfer = '0;
        end
    end

    // Compare process
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (rst_n_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("beat cyc=%0d id=%0d data=%0d last=%0b err=%0b", cyc, id_o, data_o, last_o, err_o);
                    check("data", data_o, e.data);
                    check("id", id_o, e.id);
                    check("last", last_o, e.last);
                    check("err", err_o, e.err);
                    if (first_cyc < 0) first_cyc = cyc;
                    last_cyc = cyc;
                end
            end else begin
                check("err_idle", err_o, 0);
            end
            check("ready_onehot", $countones(req_ready_o) <= 1, 1);
        end
    end

    initial begin
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_last", last_o, 0);
        check("rst_id", id_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", req_ready_o, 0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // Single requester 0, four beats, latency pinned by hand.
        first_cyc = -1;
        add_beat(0, 32'h1, 1'b0);
        add_beat(0, 32'h8, 1'b0);
        add_beat(0, 32'h100, 1'b0);
        add_beat(0, 32'h0, 1'b1);
        run_model();
        check("t1_model_d0", exp_q[0].data, 1);
        check("t1_model_d1", exp_q[1].data, 4);
        check("t1_model_d2", exp_q[2].data, 9);
        check("t1_model_d3", exp_q[3].data, 32);
        check("t1_model_last", exp_q[3].last, 1);
        @(negedge clk_i);
        check("t1_ready_t", req_ready_o, 2'b00);
        @(negedge clk_i);
        check("t1_ready_t1", req_ready_o, 2'b01);
        @(negedge clk_i);
        check("t1_valid_t2", valid_o, 1);
        check("t1_data_t2", data_o, 1);
        drain("t1");
        check("t1_span", last_cyc - first_cyc, 3);

        // Requester 1, 40 beats without last until beat 40.
        first_cyc = -1;
        add_frame(1, 40, 1'b1);
        run_model();
        check("t3_model_len", exp_q.size(), 40);
        check("t3_model_err31", exp_q[31].err, 1);
        check("t3_model_last31", exp_q[31].last, 1);
        check("t3_model_last39", exp_q[39].last, 1);
        check("t3_model_err39", exp_q[39].err, 0);
        drain("t3");
        check("t3_span", last_cyc - first_cyc, 40);

        // Both requesters, two 3-beat frames each, pointer at 0.
        first_cyc = -1;
        check("t2_ptr", mdl_ptr, 0);
        add_frame(0, 3, 1'b1);
        add_frame(0, 3, 1'b1);
        add_frame(1, 3, 1'b1);
        add_frame(1, 3, 1'b1);
        run_model();
        check("t2_model_id0", exp_q[0].id, 0);
        check("t2_model_id1", exp_q[3].id, 1);
        check("t2_model_id2", exp_q[6].id, 0);
        check("t2_model_id3", exp_q[9].id, 1);
        drain("t2");
        check("t2_span", last_cyc - first_cyc, 14);

        // Enable dropped for 5 cycles inside a frame that ends exactly at MAX_LEN.
        first_cyc = -1;
        add_frame(0, 32, 1'b1);
        run_model();
        repeat (10) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("t4_ready_off", req_ready_o, 0);
            if (i > 0) check("t4_valid_off", valid_o, 0);
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b1;
        @(negedge clk_i);
        check("t4_valid_off_last", valid_o, 0);
        drain("t4");
        check("t4_span", last_cyc - first_cyc, 36);

        // Asynchronous reset inside a frame from requester 1.
        add_frame(1, 10, 1'b1);
        run_model();
        repeat (6) @(negedge clk_i);
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b0;
        #1;
        check("t5_rst_valid", valid_o, 0);
        check("t5_rst_ready", req_ready_o, 0);
        check("t5_rst_data", data_o, 0);
        check("t5_rst_id", id_o, 0);
        check("t5_rst_last", last_o, 0);
        src_q[0].delete();
        src_q[1].delete();
        mdl_q[0].delete();
        mdl_q[1].delete();
        exp_q.delete();
        mdl_ptr = 0;
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        add_frame(0, 3, 1'b1);
        add_frame(1, 3, 1'b1);
        run_model();
        check("t5_model_first_id", exp_q[0].id, 0);
        drain("t5");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/log_sched.md
Name: log_sched

Overview:
- Frame-level scheduler that shares the single combinational log unit between NUM_REQ energy streams in the acoustic front end (e.g. several filterbank channel groups).
- Grants one requester at a time, round-robin, and holds the grant for a whole frame (until its last beat).
- Routes the requester's beats through the log unit, then registers the 8-bit result tagged with the requester ID.
- Enforces a maximum frame length and flags overlong frames.

Parameters:
- NUM_REQ, 2, number of requesting streams (2..8)
- I_BW, 32, input beat width (matches log unit input)
- O_BW, 8, log result width (matches log unit output)
- ID_BW, 1, requester ID width; equals clog2(NUM_REQ), minimum 1
- MAX_LEN, 32, maximum beats per frame before forced termination

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous assert, active-low
- en_i  in  1  global enable; low freezes all state and blocks transfers
- req_data_i  in  NUM_REQ*I_BW  requester beats; requester k occupies [k*I_BW +: I_BW]
- req_valid_i  in  NUM_REQ  per-requester beat valid
- req_last_i  in  NUM_REQ  per-requester last beat of frame
- req_ready_o  out  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high
- log_data_o  out  I_BW  beat data to shared log unit
- log_valid_o  out  1  beat valid to log unit
- log_last_o  out  1  beat last to log unit
- log_data_i  in  O_BW  log unit result, combinational from log_data_o
- log_valid_i  in  1  log unit valid
- log_last_i  in  1  log unit last
- data_o  out  O_BW  registered log result
- valid_o  out  1  registered valid
- last_o  out  1  registered last; also asserted on forced termination
- id_o  out  ID_BW  requester ID of the current output beat
- err_o  out  1  one-cycle pulse when a frame hits MAX_LEN without last

Behaviour:
- Reset values: state IDLE, rr pointer 0, grant 0, beat counter 0. All registered outputs 0: data_o, valid_o, last_o, id_o, err_o. req_ready_o = 0.
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_n_i. Reset mid-frame abandons the frame; the requester must restart its frame.
- FSM states: IDLE, BUSY.
- IDLE:
  - req_ready_o all 0.
  - If en_i and any req_valid_i: grant = first valid index at or after the rr pointer (wrapping); go to BUSY next cycle.
  - The grant is registered. First beat: valid at cycle t, ready at t+1, output at t+2.
- BUSY:
  - req_ready_o[grant] = en_i; all other ready bits are 0.
  - log_data_o/log_valid_o/log_last_o mux combinationally from the granted requester; log_valid_o = req_valid_i[grant] & en_i.
  - log_last_o = req_last_i[grant], or the forced-last condition below.
- On each transfer, the beat counter increments.
- Frame end: transfer with last, or transfer where counter == MAX_LEN-1 (forced last).
  - Go to IDLE; rr pointer = grant+1, wrapping at NUM_REQ; counter = 0.
- Forced termination:
  - last_o = 1 on that beat.
  - err_o pulses together with that output beat.
  - The requester's remaining beats form a new frame that must re-arbitrate.
- Output register:
  - Loads on every cycle with en_i high: valid_o = log_valid_i; data_o = log_data_i; last_o = log_last_i; id_o = grant.
  - Latency from transfer to output is 1 cycle. No backpressure on the output side.
- en_i low: no transfers, FSM/counter/pointer hold, valid_o and err_o drop to 0 next cycle, data_o/id_o hold.
- Fairness: after a frame from k, requester k has lowest priority. Back-to-back frames cost one IDLE bubble cycle.
- Boundary cases:
  - Simultaneous requests → rr order.
  - Single-beat frame (valid & last on first beat) → returns to IDLE after one beat.
  - Non-granted requester valid is ignored; its data must stay held, per valid/ready rules.

Decomposition:
- Package log_sched_pkg:
  - state enum {IDLE, BUSY}
  - localparams LOG_I_BW=32, LOG_O_BW=8
  - a clog2 helper for ID_BW
- Sub-module rr_arbiter:
  - inputs: NUM_REQ request vector, pointer
  - outputs: grant index, any-request flag
  - purely combinational, reusable elsewhere.

Test Plan:
- Single requester 0, frame of 4 beats with data 0x1, 0x8, 0x100, 0x0, last on beat 4. Expect data_o 1, 4, 9, 32; id_o 0; last_o on 4th output; each output 1 cycle after its transfer; first ready 1 cycle after valid.
- Both requesters continuously valid, 3-beat frames, pointer 0. Expect grant sequence 0, 1, 0, 1; one IDLE bubble between frames; id_o matches; no beat from the non-granted requester is accepted.
- Requester 1 sends 40 beats without last (MAX_LEN=32). Expect beat 32 output with last_o=1 and err_o=1; grant released; the next 8 beats go out as a new frame after re-arbitration.
- en_i dropped for 5 cycles mid-frame. Expect req_ready_o=0, valid_o=0 from the next cycle; counter and grant held; frame resumes and completes with correct beat count after en_i returns.
- rst_n_i asserted asynchronously mid-frame (between clock edges). Expect immediate zero outputs and IDLE; after release, arbitration restarts from requester 0.
